// File: rtl/poly1305_pkg.sv
// rtl/poly1305_pkg.sv - shared constants, FSM states and helpers for the poly1305 multiply scheduler
package poly1305_pkg;

    localparam int NUM_LIMBS = 5;
    localparam int OPA_W     = 32;
    localparam int OPB_W     = 64;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_ISSUE = 2'd1,
        CTRL_WAIT  = 2'd2
    } ctrl_state_t;

    // 5*r as {r,2'b0}+r, kept to OPA_W bits like the multiplier operand port
    function automatic logic [OPA_W-1:0] times5(input logic [OPA_W-1:0] r);
        return {r[OPA_W-3:0], 2'b00} + r;
    endfunction

endpackage

// File: rtl/poly1305_mulacc_sched_if.sv
// rtl/poly1305_mulacc_sched_if.sv - request/result bundle between the poly1305 core FSM and the multiply scheduler
interface poly1305_mulacc_sched_if;
    logic        start;
    logic        ready;
    logic [63:0] h0, h1, h2, h3, h4;
    logic [31:0] r0, r1, r2, r3, r4;
    logic [63:0] d0, d1, d2, d3, d4;

    modport master (
        output start, h0, h1, h2, h3, h4, r0, r1, r2, r3, r4,
        input  ready, d0, d1, d2, d3, d4
    );

    modport slave (
        input  start, h0, h1, h2, h3, h4, r0, r1, r2, r3, r4,
        output ready, d0, d1, d2, d3, d4
    );
endinterface

// File: rtl/poly1305_mulacc.sv
// rtl/poly1305_mulacc.sv - serial five-term multiply-accumulate, one product per cycle, mod 2^64
module poly1305_mulacc
    import poly1305_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [OPA_W-1:0] i_opa [NUM_LIMBS],
    input  logic [OPB_W-1:0] i_opb [NUM_LIMBS],
    output logic [OPB_W-1:0] o_sum
);

    logic             r_ready;
    logic [2:0]       r_idx;
    logic [OPB_W-1:0] r_acc;
    logic [OPB_W-1:0] w_prod;

    // Operands are read live each cycle; the caller keeps them stable while busy
    assign w_prod  = i_opb[r_idx] * {{(OPB_W-OPA_W){1'b0}}, i_opa[r_idx]};
    assign o_ready = r_ready;
    assign o_sum   = r_acc;

    // Accept a job when idle, then add one product per cycle for five cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_idx   <= 3'd0;
            r_acc   <= '0;
        end else if (r_ready) begin
            if (i_start) begin
                r_ready <= 1'b0;
                r_idx   <= 3'd0;
                r_acc   <= '0;
            end
        end else begin
            r_acc <= r_acc + w_prod;
            if (r_idx == 3'(NUM_LIMBS - 1)) begin
                r_ready <= 1'b1;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/poly1305_mulacc_sched.sv
// rtl/poly1305_mulacc_sched.sv - runs one shared mulacc over the five limbs of d = h*r mod 2^130-5
module poly1305_mulacc_sched
    import poly1305_pkg::*;
(
    input  logic clk,
    input  logic reset,
    poly1305_mulacc_sched_if.slave bus
);

    ctrl_state_t      r_state;
    logic             r_ready;
    logic             r_mac_start;
    logic             r_seen_busy;
    logic [2:0]       r_limb_ctr;
    logic [OPB_W-1:0] r_h [NUM_LIMBS];
    logic [OPA_W-1:0] r_r [NUM_LIMBS];
    logic [OPA_W-1:0] r_s [NUM_LIMBS];
    logic [OPB_W-1:0] r_d [NUM_LIMBS];

    logic [OPA_W-1:0] w_opa [NUM_LIMBS];
    logic [OPB_W-1:0] w_opb [NUM_LIMBS];
    logic             w_mac_ready;
    logic [OPB_W-1:0] w_mac_sum;

    assign bus.ready = r_ready;
    assign bus.d0    = r_d[0];
    assign bus.d1    = r_d[1];
    assign bus.d2    = r_d[2];
    assign bus.d3    = r_d[3];
    assign bus.d4    = r_d[4];

    // Route operands for limb k: slot j pairs h_j with r[k-j], or s[5+k-j] once the index wraps
    always_comb begin
        w_opa = '{default: '0};
        w_opb = '{default: '0};
        for (int j = 0; j < NUM_LIMBS; j++) begin
            if (r_limb_ctr >= 3'(j)) begin
                w_opa[j] = r_r[r_limb_ctr - 3'(j)];
            end else begin
                w_opa[j] = r_s[3'd5 + r_limb_ctr - 3'(j)];
            end
            w_opb[j] = r_h[j];
        end
    end

    poly1305_mulacc u_mulacc (
        .clk     (clk),
        .reset_n (~reset),
        .i_start (r_mac_start),
        .o_ready (w_mac_ready),
        .i_opa   (w_opa),
        .i_opb   (w_opb),
        .o_sum   (w_mac_sum)
    );

    // Control FSM: latch operands, issue one job per limb, capture each limb sum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CTRL_IDLE;
            r_ready     <= 1'b1;
            r_mac_start <= 1'b0;
            r_seen_busy <= 1'b0;
            r_limb_ctr  <= 3'd0;
            r_h         <= '{default: '0};
            r_r         <= '{default: '0};
            r_s         <= '{default: '0};
            r_d         <= '{default: '0};
        end else begin
            case (r_state)
                CTRL_IDLE: begin
                    if (bus.start) begin
                        r_h[0]      <= bus.h0;
                        r_h[1]      <= bus.h1;
                        r_h[2]      <= bus.h2;
                        r_h[3]      <= bus.h3;
                        r_h[4]      <= bus.h4;
                        r_r[0]      <= bus.r0;
                        r_r[1]      <= bus.r1;
                        r_r[2]      <= bus.r2;
                        r_r[3]      <= bus.r3;
                        r_r[4]      <= bus.r4;
                        r_s[0]      <= times5(bus.r0);
                        r_s[1]      <= times5(bus.r1);
                        r_s[2]      <= times5(bus.r2);
                        r_s[3]      <= times5(bus.r3);
                        r_s[4]      <= times5(bus.r4);
                        r_limb_ctr  <= 3'd0;
                        r_ready     <= 1'b0;
                        r_mac_start <= 1'b1;
                        r_state     <= CTRL_ISSUE;
                    end
                end
                CTRL_ISSUE: begin
                    r_mac_start <= 1'b0;
                    r_seen_busy <= 1'b0;
                    r_state     <= CTRL_WAIT;
                end
                CTRL_WAIT: begin
                    // mulacc ready is still high from the previous job until it samples our start
                    if (!w_mac_ready) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_d[r_limb_ctr] <= w_mac_sum;
                        if (r_limb_ctr == 3'(NUM_LIMBS - 1)) begin
                            r_ready <= 1'b1;
                            r_state <= CTRL_IDLE;
                        end else begin
                            r_limb_ctr  <= r_limb_ctr + 3'd1;
                            r_mac_start <= 1'b1;
                            r_state     <= CTRL_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= CTRL_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
